i2c_txn_sequencer: RTL

//  Command-queue front end for i2c_master. Buffers write/read transactions from a host in a

---
 rtl/i2c_txn_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_txn_sequencer.sv
// Command-queue front end for i2c_master: buffers host transactions, launches them one at a time,
// and returns {tmo, nack, data} per command. Optional NACK retry enabled by defining I2C_RETRY_EN.
module i2c_txn_sequencer #(
    parameter int CMD_DEPTH      = 4,
    parameter int LAUNCH_TIMEOUT = 64,
    parameter int GAP_CYCLES     = 8,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_nack,
    output logic       rsp_tmo,
    output logic       m_start,
    output logic       m_rw,
    output logic [6:0] m_addr,
    output logic [7:0] m_data_in,
    input  logic [7:0] m_data_out,
    input  logic       m_ack_error,
    input  logic       m_busy,
    output logic       seq_busy,
    output logic [2:0] dbg_state
);

    localparam int            PW      = $clog2(CMD_DEPTH);
    localparam logic [PW:0]   DEPTH_L = (PW + 1)'(CMD_DEPTH);
    localparam logic [7:0]    TMO_L   = 8'(LAUNCH_TIMEOUT);
    localparam logic [7:0]    GAP_L   = 8'(GAP_CYCLES - 1);

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("CMD_DEPTH must be a power of two and at least 2");
    end
    if (MAX_RETRY < 0 || MAX_RETRY > 7) begin : g_bad_retry
        $error("MAX_RETRY must be in 0..7");
    end

    typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP, S_GAP} state_t;

    state_t          state, state_nxt, gap_or_idle;
    logic [15:0]     mem [CMD_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [PW:0]     count, count_nxt;
    logic [7:0]      tmo_cnt, gap_cnt;
    logic            push, pop, tmo_hit, gap_done, retry_go, retry_pend;

    // valid/ready: a beat transfers on any cycle where both are high; the producer
    // holds its payload stable while valid is high and ready is low.
    assign push        = cmd_valid && cmd_ready;
    assign tmo_hit     = (state == S_LAUNCH) && (tmo_cnt == TMO_L);
    assign gap_done    = (state == S_GAP) && (gap_cnt == GAP_L);
    assign gap_or_idle = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
    assign seq_busy    = (state != S_IDLE) || (count != '0);
    assign dbg_state   = state;

`ifdef I2C_RETRY_EN
    logic [2:0] retry_cnt;

    assign retry_go = (state == S_WAIT) && !m_busy && m_ack_error && (int'(retry_cnt) < MAX_RETRY);

    // A pending retry relaunches the held command without touching the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
        end else begin
            if (pop)
                retry_cnt <= '0;
            else if (retry_go)
                retry_cnt <= retry_cnt + 1'b1;
            if (retry_go)
                retry_pend <= 1'b1;
            else if (state == S_IDLE)
                retry_pend <= 1'b0;
        end
    end
`else
    assign retry_go   = 1'b0;
    assign retry_pend = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (retry_pend) begin
                    state_nxt = S_LAUNCH;
                end else if (count != '0 && !rsp_valid) begin
                    state_nxt = S_LAUNCH;
                    pop       = 1'b1;
                end
            end
            S_LAUNCH: begin
                if (m_busy)
                    state_nxt = S_WAIT;
                else if (tmo_hit)
                    state_nxt = S_RESP;
            end
            S_WAIT: begin
                if (!m_busy)
                    state_nxt = retry_go ? gap_or_idle : S_RESP;
            end
            S_RESP: begin
                if (rsp_ready)
                    state_nxt = gap_or_idle;
            end
            S_GAP: begin
                if (gap_done)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b1;
            m_start   <= 1'b0;
            m_rw      <= 1'b0;
            m_addr    <= '0;
            m_data_in <= '0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_nack  <= 1'b0;
            rsp_tmo   <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            cmd_ready <= (count_nxt != DEPTH_L);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr                      <= rd_ptr + 1'b1;
                {m_rw, m_addr, m_data_in}   <= mem[rd_ptr];
            end
            // Registered start: rises one cycle after LAUNCH entry, drops on the exit edge.
            m_start <= (state == S_LAUNCH) && (state_nxt == S_LAUNCH);
            tmo_cnt <= (state == S_LAUNCH) ? tmo_cnt + 1'b1 : '0;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
            if (state == S_LAUNCH && state_nxt == S_RESP) begin
                rsp_valid <= 1'b1;
                rsp_tmo   <= 1'b1;
                rsp_nack  <= 1'b0;
                rsp_data  <= '0;
            end else if (state == S_WAIT && state_nxt == S_RESP) begin
                rsp_valid <= 1'b1;
                rsp_tmo   <= 1'b0;
                rsp_nack  <= m_ack_error;
                rsp_data  <= m_rw ? m_data_out : 8'h00;
            end else if (state == S_RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_tmo   <= 1'b0;
                rsp_nack  <= 1'b0;
                rsp_data  <= '0;
            end
        end
    end

endmodule
